// File: rtl/rx_pcrc_ctrl.sv
// rx_pcrc_ctrl: receive-side preface CRC sequencer for CAN XL.
// Tracks SOF..last covered header bit, gates the PCRC engine,
// shifts in the 13-bit PCRC field and reports ok/err.
// Ports:
//   clk, g_rst       clock, async active-high reset
//   bit_strobe       sample-point pulse, rx_bit valid
//   rx_bit           sampled bus bit (0 = dominant)
//   de_stuff         strobed bit is a stuff bit
//   rx_abort         abandon the current check
//   pcrc_frm         computed CRC from the engine
//   pcrc_enable      engine update enable
//   pcrc_init        engine initialize
//   hdr_active       in header phase
//   fld_active       in field phase
//   rx_pcrc          received PCRC field
//   pcrc_ok/err      one-cycle result pulses
module rx_pcrc_ctrl #(
   parameter int HDR_BITS = 39,
   parameter int PCRC_W   = 13
) (
   input  logic              clk,
   input  logic              g_rst,
   input  logic              bit_strobe,
   input  logic              rx_bit,
   input  logic              de_stuff,
   input  logic              rx_abort,
   input  logic [PCRC_W-1:0] pcrc_frm,
   output logic              pcrc_enable,
   output logic              pcrc_init,
   output logic              hdr_active,
   output logic              fld_active,
   output logic [PCRC_W-1:0] rx_pcrc,
   output logic              pcrc_ok,
   output logic              pcrc_err
);

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      FLD,
      CHK
   } state_t;

   localparam logic [5:0] HDR_LAST = 6'(HDR_BITS - 1);
   localparam logic [5:0] FLD_LAST = 6'(PCRC_W - 1);

   state_t            r_state;
   logic [5:0]        r_bit_cnt;
   logic [PCRC_W-1:0] r_rx_pcrc;

   logic w_vbit;
   logic w_match;

   // Stuff bits are invisible to counting, CRC and field capture.
   assign w_vbit  = bit_strobe & ~de_stuff;
   assign w_match = (r_rx_pcrc == pcrc_frm);

   always_ff @(posedge clk or posedge g_rst) begin
      if (g_rst) begin
         r_state   <= IDLE;
         r_bit_cnt <= '0;
         r_rx_pcrc <= '0;
      end else if (rx_abort) begin
         r_state   <= IDLE;
         r_bit_cnt <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_vbit && !rx_bit) begin
                  r_state   <= HDR;
                  r_bit_cnt <= 6'd1;
                  r_rx_pcrc <= '0;
               end
            end
            HDR: begin
               if (w_vbit) begin
                  if (r_bit_cnt == HDR_LAST) begin
                     r_state   <= FLD;
                     r_bit_cnt <= '0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 6'd1;
                  end
               end
            end
            FLD: begin
               if (w_vbit) begin
                  r_rx_pcrc <= {r_rx_pcrc[PCRC_W-2:0], rx_bit};
                  r_bit_cnt <= r_bit_cnt + 6'd1;
                  if (r_bit_cnt == FLD_LAST) begin
                     r_state <= CHK;
                  end
               end
            end
            CHK: begin
               r_state   <= IDLE;
               r_bit_cnt <= '0;
            end
            default: begin
               r_state   <= IDLE;
               r_bit_cnt <= '0;
            end
         endcase
      end
   end

   // Engine strobes on the same edge as the bit; abort wins.
   assign pcrc_enable = (r_state == HDR) & w_vbit & ~rx_abort;
   assign pcrc_init   = (r_state == IDLE);
   assign hdr_active  = (r_state == HDR);
   assign fld_active  = (r_state == FLD);
   assign rx_pcrc     = r_rx_pcrc;
   assign pcrc_ok     = (r_state == CHK) & ~rx_abort & w_match;
   assign pcrc_err    = (r_state == CHK) & ~rx_abort & ~w_match;

endmodule

// File: tb/tb_rx_pcrc_ctrl.sv
// tb_rx_pcrc_ctrl: randomized scoreboard bench for rx_pcrc_ctrl.
// Includes a CRC-13 engine model fed by the DUT's enable/init.
module tb_rx_pcrc_ctrl;

   localparam int H = 39;
   localparam logic [12:0] POLY = 13'h19E7;

   logic        clk = 1'b0;
   logic        g_rst = 1'b1;
   logic        bit_strobe = 1'b0;
   logic        rx_bit = 1'b1;
   logic        de_stuff = 1'b0;
   logic        rx_abort = 1'b0;
   logic [12:0] pcrc_frm;
   logic        pcrc_enable, pcrc_init;
   logic        hdr_active, fld_active;
   logic [12:0] rx_pcrc;
   logic        pcrc_ok, pcrc_err;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct {
      bit          ok;
      logic [12:0] rx;
      int          cyc;
   } exp_t;
   exp_t q[$];

   rx_pcrc_ctrl #(.HDR_BITS(H), .PCRC_W(13)) dut (
      .clk(clk), .g_rst(g_rst), .bit_strobe(bit_strobe),
      .rx_bit(rx_bit), .de_stuff(de_stuff), .rx_abort(rx_abort),
      .pcrc_frm(pcrc_frm), .pcrc_enable(pcrc_enable),
      .pcrc_init(pcrc_init), .hdr_active(hdr_active),
      .fld_active(fld_active), .rx_pcrc(rx_pcrc),
      .pcrc_ok(pcrc_ok), .pcrc_err(pcrc_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [12:0] crc_step(logic [12:0] c, logic b);
      logic fb;
      fb = c[12] ^ b;
      return {c[11:0], 1'b0} ^ (fb ? POLY : 13'h0);
   endfunction

   // PCRC engine model driven by the DUT control outputs.
   always @(posedge clk or posedge g_rst) begin
      if (g_rst) pcrc_frm <= '0;
      else if (pcrc_init) pcrc_frm <= '0;
      else if (pcrc_enable) pcrc_frm <= crc_step(pcrc_frm, rx_bit);
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!g_rst && (pcrc_ok || pcrc_err)) begin
         check("ok_err_exclusive", 32'(pcrc_ok & pcrc_err), 0);
         if (q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("result_ok", 32'(pcrc_ok), 32'(e.ok));
            check("result_err", 32'(pcrc_err), 32'(!e.ok));
            check("rx_pcrc", 32'(rx_pcrc), 32'(e.rx));
            check("result_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Three-clock bit period; returns 1 time unit after the
   // edge that sampled the strobe.
   task automatic strobe(input logic b, input logic s, input logic a);
      repeat (2) @(posedge clk);
      #1;
      bit_strobe = 1'b1;
      rx_bit     = b;
      de_stuff   = s;
      rx_abort   = a;
      @(posedge clk);
      #1;
      bit_strobe = 1'b0;
      de_stuff   = 1'b0;
      rx_abort   = 1'b0;
      rx_bit     = 1'b1;
   endtask

   task automatic send_hdr(input bit zero, input bit stuff,
                           output logic [12:0] golden);
      logic hb;
      golden = '0;
      strobe(1'b0, 1'b0, 1'b0);
      for (int i = 2; i <= H; i++) begin
         hb = zero ? 1'b0 : 1'($urandom);
         golden = crc_step(golden, hb);
         if (stuff && (i % 5 == 0)) strobe(1'($urandom), 1'b1, 1'b0);
         strobe(hb, 1'b0, 1'b0);
      end
   endtask

   task automatic run_frame(input bit zero, input bit stuff,
                            input logic [12:0] flip);
      logic [12:0] golden, fld;
      exp_t e;
      send_hdr(zero, stuff, golden);
      check("fld_entry", 32'(fld_active), 1);
      check("crc_final", 32'(pcrc_frm), 32'(golden));
      fld = golden ^ flip;
      for (int j = 12; j >= 0; j--) begin
         if (stuff && (j == 9 || j == 4)) strobe(1'($urandom), 1'b1, 1'b0);
         strobe(fld[j], 1'b0, 1'b0);
      end
      e.ok  = (fld == golden);
      e.rx  = fld;
      e.cyc = cyc;
      q.push_back(e);
      @(posedge clk);
      #1;
      check("rx_pcrc_held", 32'(rx_pcrc), 32'(fld));
      check("idle_after_chk", 32'(pcrc_init), 1);
   endtask

   initial begin
      logic [12:0] g;
      #2;
      check("rst_init", 32'(pcrc_init), 1);
      check("rst_enable", 32'(pcrc_enable), 0);
      check("rst_hdr", 32'(hdr_active), 0);
      check("rst_fld", 32'(fld_active), 0);
      check("rst_rx", 32'(rx_pcrc), 0);
      check("rst_okerr", 32'({pcrc_ok, pcrc_err}), 0);
      repeat (3) @(posedge clk);
      #1 g_rst = 1'b0;

      run_frame(1'b1, 1'b0, 13'h0000);
      run_frame(1'b0, 1'b0, 13'h0000);
      run_frame(1'b0, 1'b0, 13'h0001);
      run_frame(1'b0, 1'b1, 13'h0000);
      run_frame(1'b0, 1'b1, 13'(1 << $urandom_range(12, 0)));

      // Abort at header bit 20.
      strobe(1'b0, 1'b0, 1'b0);
      for (int i = 2; i < 20; i++) strobe(1'($urandom), 1'b0, 1'b0);
      check("hdr_mid", 32'(hdr_active), 1);
      strobe(1'b1, 1'b0, 1'b1);
      check("abort_idle", 32'(hdr_active), 0);
      check("abort_init", 32'(pcrc_init), 1);
      repeat (10) @(posedge clk);
      run_frame(1'b0, 1'b0, 13'h0000);

      // Reset while receiving field bit 6.
      send_hdr(1'b0, 1'b0, g);
      for (int j = 0; j < 5; j++) strobe(1'b1, 1'b0, 1'b0);
      check("fld_partial", 32'(rx_pcrc), 32'h1F);
      repeat (2) @(posedge clk);
      #1;
      bit_strobe = 1'b1;
      rx_bit = 1'b1;
      g_rst = 1'b1;
      #1;
      check("arst_fld", 32'(fld_active), 0);
      check("arst_init", 32'(pcrc_init), 1);
      check("arst_enable", 32'(pcrc_enable), 0);
      check("arst_rx", 32'(rx_pcrc), 0);
      check("arst_okerr", 32'({pcrc_ok, pcrc_err}), 0);
      @(posedge clk);
      #1;
      bit_strobe = 1'b0;
      g_rst = 1'b0;
      check("arst_hold", 32'({hdr_active, fld_active}), 0);

      // Back-to-back frames.
      run_frame(1'b0, 1'b0, 13'h0000);
      run_frame(1'b0, 1'b1, 13'h0000);
      for (int k = 0; k < 4; k++)
         run_frame(1'b0, 1'($urandom), 13'($urandom_range(1, 0)));

      repeat (20) @(posedge clk);
      while (q.size() != 0) begin
         void'(q.pop_front());
         check("missing_pulse", 0, 1);
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
